cipher_round_ctrl: RTL and testbench

CIPHER_ROUND_CTRL -- requirements
Module: cipher_round_ctrl

---
 rtl/cipher_round_ctrl_if.sv | 23 ++
 rtl/cipher_round_ctrl.sv | 179 +++++++++++++++++
 tb/tb_cipher_round_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cipher_round_ctrl_if.sv
// Handshake and data bundle for the iterative AES-128 round controller.
// The master side supplies plaintext/key and accepts ciphertext; the slave
// side is the controller itself.
interface cipher_round_ctrl_if;
    logic         InValid_SI;
    logic         InReady_SO;
    logic [127:0] Plaintext_DI;
    logic [127:0] Key_DI;
    logic         OutValid_SO;
    logic         OutReady_SI;
    logic [127:0] Ciphertext_DO;
    logic         Busy_SO;

    modport master (
        output InValid_SI, Plaintext_DI, Key_DI, OutReady_SI,
        input  InReady_SO, OutValid_SO, Ciphertext_DO, Busy_SO
    );

    modport slave (
        input  InValid_SI, Plaintext_DI, Key_DI, OutReady_SI,
        output InReady_SO, OutValid_SO, Ciphertext_DO, Busy_SO
    );
endinterface

// File: rtl/cipher_round_ctrl.sv
// Iterative AES-128 encryption controller: one round datapath reused for
// ten rounds, with the round key expanded on the fly alongside the state.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a plaintext/key pair, InReady_SO high
// ST_ROUND | one round per edge, counter 1..10, Busy_SO high
// ST_DONE  | ciphertext held in the state register until OutReady_SI
//
// Byte i of a 128-bit block sits at bits [127-8*i -: 8]; the AES matrix is
// column-major, so byte i is row (i % 4), column (i / 4).
module cipher_round_ctrl (
    input  logic                  Clk_CI,
    input  logic                  Rst_RI,
    cipher_round_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e       fsm_q;
    logic [127:0] state_q;
    logic [127:0] key_q;
    logic [3:0]   cnt_q;
    logic [7:0]   rcon_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [127:0] key_d;
    logic [127:0] sbsr_d;
    logic [127:0] round_d;
    logic [127:0] last_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by
    // the affine transform, instead of a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c    -: 8];
            a1 = s[127-32*c-8  -: 8];
            a2 = s[127-32*c-16 -: 8];
            a3 = s[127-32*c-24 -: 8];
            o[127-32*c    -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127-32*c-8  -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127-32*c-16 -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127-32*c-24 -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3r;
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        w3r = {k[23:0], k[31:24]};
        t   = {sbox(w3r[31:24]) ^ rc, sbox(w3r[23:16]), sbox(w3r[15:8]), sbox(w3r[7:0])};
        n0  = k[127:96] ^ t;
        n1  = k[95:64]  ^ n0;
        n2  = k[63:32]  ^ n1;
        n3  = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Shared datapath: next round key and both round flavours from current regs.
    always_comb begin
        key_d   = key_expand(key_q, rcon_q);
        sbsr_d  = sub_shift(state_q);
        round_d = mix_columns(sbsr_d) ^ key_d;
        last_d  = sbsr_d ^ key_d;
    end

    // Sequencer: accept, ten rounds, hold result until downstream takes it.
    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            key_q       <= '0;
            cnt_q       <= 4'd0;
            rcon_q      <= 8'h01;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (bus.InValid_SI) begin
                        state_q    <= bus.Plaintext_DI ^ bus.Key_DI;
                        key_q      <= bus.Key_DI;
                        cnt_q      <= 4'd1;
                        rcon_q     <= 8'h01;
                        fsm_q      <= ST_ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ST_ROUND: begin
                    key_q <= key_d;
                    // >= rather than == so a corrupted counter still terminates
                    if (cnt_q >= 4'd10) begin
                        state_q     <= last_d;
                        cnt_q       <= 4'd10;
                        fsm_q       <= ST_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        state_q <= round_d;
                        cnt_q   <= cnt_q + 4'd1;
                        rcon_q  <= xtime(rcon_q);
                    end
                end
                ST_DONE: begin
                    if (bus.OutReady_SI) begin
                        fsm_q       <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    fsm_q       <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InReady_SO    = in_ready_q;
    assign bus.OutValid_SO   = out_valid_q;
    assign bus.Busy_SO       = busy_q;
    assign bus.Ciphertext_DO = state_q;

endmodule

// File: tb/tb_cipher_round_ctrl.sv
// Testbench for cipher_round_ctrl: scoreboard fed at each accept from a
// table-driven AES-128 reference model, monitor compares on OutValid_SO.
module tb_cipher_round_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    cipher_round_ctrl_if bus_if ();

    cipher_round_ctrl dut (
        .Clk_CI (clk),
        .Rst_RI (rst),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    function automatic logic [7:0] ref_sbox(input logic [7:0] x);
        logic [2047:0] tab;
        tab = SBOX_TAB;
        return tab[2047 - 8*x -: 8];
    endfunction

    function automatic logic [7:0] m2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Textbook AES-128: full key schedule up front, then ten rounds on a byte array.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   w [176];
        logic [7:0]   tw [4];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = key[127-8*i -: 8];
        end
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tw[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tw = '{ref_sbox(w[i-3]) ^ RCON[i/16-1], ref_sbox(w[i-2]),
                       ref_sbox(w[i-1]), ref_sbox(w[i-4])};
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tw[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = ref_sbox(s[i]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row+4*c] = t[row+4*((c+row)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) tw[j] = s[4*c+j];
                    s[4*c]   = m2(tw[0]) ^ m2(tw[1]) ^ tw[1] ^ tw[2] ^ tw[3];
                    s[4*c+1] = tw[0] ^ m2(tw[1]) ^ m2(tw[2]) ^ tw[2] ^ tw[3];
                    s[4*c+2] = tw[0] ^ tw[1] ^ m2(tw[2]) ^ m2(tw[3]) ^ tw[3];
                    s[4*c+3] = m2(tw[0]) ^ tw[0] ^ tw[1] ^ tw[2] ^ m2(tw[3]);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [127:0] ct;
        int           due;
    } exp_t;

    exp_t         exp_q [$];
    int           acc_cycles [$];
    int           hs_count = 0;
    logic         prev_ov  = 1'b0;
    logic [127:0] held_ct  = '0;

    // Monitor: samples on the falling edge, predicts accepts for the next
    // rising edge and scores every OutValid_SO rise against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus_if.InValid_SI && bus_if.InReady_SO) begin
                e.ct  = aes_ref(bus_if.Plaintext_DI, bus_if.Key_DI);
                e.due = cyc + 1 + 10;
                exp_q.push_back(e);
                acc_cycles.push_back(cyc + 1);
            end
            if (bus_if.OutValid_SO && !prev_ov) begin
                check("scoreboard_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("ciphertext", bus_if.Ciphertext_DO, e.ct);
                    check("latency", cyc, e.due);
                end
                held_ct = bus_if.Ciphertext_DO;
            end else if (bus_if.OutValid_SO) begin
                check("ct_hold", bus_if.Ciphertext_DO, held_ct);
            end
            if (bus_if.OutValid_SO && bus_if.OutReady_SI) hs_count++;
        end
        if (cyc > 0)
            check("status_onehot",
                  $countones({bus_if.InReady_SO, bus_if.Busy_SO, bus_if.OutValid_SO}), 1);
        prev_ov = bus_if.OutValid_SO;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_ov(input int limit);
        int n = 0;
        while (!bus_if.OutValid_SO && n < limit) begin
            step();
            n++;
        end
        check("out_valid_arrived", bus_if.OutValid_SO, 1'b1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (!bus_if.InReady_SO && n < limit) begin
            step();
            n++;
        end
        check("in_ready_arrived", bus_if.InReady_SO, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  bus_if.InReady_SO, 1'b1);
        check({tag, "_out_valid"}, bus_if.OutValid_SO, 1'b0);
        check({tag, "_busy"},      bus_if.Busy_SO, 1'b0);
        check({tag, "_ct_zero"},   bus_if.Ciphertext_DO, 128'h0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        logic [127:0] v_pt, v_key, v_exp;
        int h0, a0, n;

        bus_if.InValid_SI   = 1'b0;
        bus_if.OutReady_SI  = 1'b0;
        bus_if.Plaintext_DI = '0;
        bus_if.Key_DI       = '0;

        // Reset, then accept on the very first edge without reset.
        step(); step();
        check_reset_outputs("reset");
        rst = 1'b0;
        bus_if.InValid_SI   = 1'b1;
        bus_if.Plaintext_DI = C1_PT;
        bus_if.Key_DI       = C1_KEY;
        bus_if.OutReady_SI  = 1'b1;
        step();
        check("first_edge_accept", bus_if.Busy_SO, 1'b1);
        bus_if.InValid_SI   = 1'b0;
        bus_if.Plaintext_DI = rnd128();
        bus_if.Key_DI       = rnd128();
        wait_ov(30);
        check("c1_ct", bus_if.Ciphertext_DO, C1_CT);

        // FIPS-197 appendix B with 20 cycles of backpressure and input noise.
        wait_idle(10);
        bus_if.OutReady_SI  = 1'b0;
        bus_if.InValid_SI   = 1'b1;
        bus_if.Plaintext_DI = B_PT;
        bus_if.Key_DI       = B_KEY;
        step();
        bus_if.InValid_SI = 1'b0;
        wait_ov(30);
        for (int i = 0; i < 20; i++) begin
            bus_if.InValid_SI   = 1'b1;
            bus_if.Plaintext_DI = rnd128();
            bus_if.Key_DI       = rnd128();
            step();
            check("bp_ct_stable", bus_if.Ciphertext_DO, B_CT);
            check("bp_in_ready_low", bus_if.InReady_SO, 1'b0);
        end
        bus_if.InValid_SI  = 1'b0;
        bus_if.OutReady_SI = 1'b1;
        step();
        check("bp_release", bus_if.InReady_SO, 1'b1);

        // InValid_SI held high with changing data during ROUND and DONE.
        h0 = hs_count;
        a0 = acc_cycles.size();
        v_pt  = rnd128();
        v_key = rnd128();
        v_exp = aes_ref(v_pt, v_key);
        bus_if.OutReady_SI  = 1'b0;
        bus_if.InValid_SI   = 1'b1;
        bus_if.Plaintext_DI = v_pt;
        bus_if.Key_DI       = v_key;
        step();
        n = 0;
        while (!bus_if.OutValid_SO && n < 30) begin
            bus_if.Plaintext_DI = rnd128();
            bus_if.Key_DI       = rnd128();
            step();
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            bus_if.Plaintext_DI = rnd128();
            step();
        end
        check("intf_ct", bus_if.Ciphertext_DO, v_exp);
        bus_if.InValid_SI  = 1'b0;
        bus_if.OutReady_SI = 1'b1;
        step(); step(); step();
        check("intf_handshakes", hs_count - h0, 1);
        check("intf_accepts", acc_cycles.size() - a0, 1);

        // Reset with the round counter at 5 discards the block.
        wait_idle(10);
        h0 = hs_count;
        bus_if.InValid_SI   = 1'b1;
        bus_if.Plaintext_DI = rnd128();
        bus_if.Key_DI       = rnd128();
        step();
        bus_if.InValid_SI = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("pre_reset_busy", bus_if.Busy_SO, 1'b1);
        rst = 1'b1;
        step();
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("mid_reset_no_output", hs_count - h0, 0);
        bus_if.InValid_SI   = 1'b1;
        bus_if.Plaintext_DI = C1_PT;
        bus_if.Key_DI       = C1_KEY;
        step();
        bus_if.InValid_SI = 1'b0;
        wait_ov(30);
        check("c1_after_reset_ct", bus_if.Ciphertext_DO, C1_CT);

        // Back-to-back: both handshakes tied high, data changes every cycle.
        wait_idle(10);
        a0 = acc_cycles.size();
        bus_if.OutReady_SI = 1'b1;
        bus_if.InValid_SI  = 1'b1;
        n = 0;
        while (acc_cycles.size() - a0 < 8 && n < 200) begin
            bus_if.Plaintext_DI = rnd128();
            bus_if.Key_DI       = rnd128();
            step();
            n++;
        end
        bus_if.InValid_SI = 1'b0;
        check("b2b_accept_count", acc_cycles.size() - a0, 8);
        for (int k = 1; k < 8; k++) begin
            if (a0 + k < acc_cycles.size())
                check("b2b_spacing", acc_cycles[a0+k] - acc_cycles[a0+k-1], 12);
        end
        n = 0;
        while ((exp_q.size() != 0 || !bus_if.InReady_SO) && n < 40) begin
            step();
            n++;
        end
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
